// File: rtl/axi_lite_master_1txn.sv
// -----------------------------------------------------------------------------
// axi_lite_master_1txn
// Self-starting AXI4-Lite master. After reset release it writes
// C_TRANSACTIONS_NUM words (addr C_START_ADDR + 4*i, data C_START_DATA + i),
// then reads the same addresses back in order, one transaction at a time.
// WCOMPLETE / RCOMPLETE are sticky until reset.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN : clock, asynchronous active-low reset
//   WCOMPLETE, RCOMPLETE      : sticky phase-done flags
//   M_AXI_AW* / W* / B*       : write address, data and response channels
//   M_AXI_AR* / R*            : read address and data channels
// BRESP / RRESP / RDATA are accepted but never inspected.
// -----------------------------------------------------------------------------
module axi_lite_master_1txn #(
    parameter int                              C_TRANSACTIONS_NUM = 1,
    parameter int                              C_M_AXI_ADDR_WIDTH = 32,
    parameter int                              C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   C_START_ADDR       = '0,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0]   C_START_DATA       = C_M_AXI_DATA_WIDTH'(1)
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    output logic                              WCOMPLETE,
    output logic                              RCOMPLETE,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    // 9 bits hold the count up to and including 256
    localparam int IW = 9;
    localparam logic [IW-1:0] LAST_CNT = IW'(C_TRANSACTIONS_NUM);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_idx, w_idx_nxt, w_idx_inc;
    logic            r_awvalid, w_awvalid_nxt;
    logic            r_wvalid, w_wvalid_nxt;
    logic            r_aw_done, w_aw_done_nxt;
    logic            r_w_done, w_w_done_nxt;
    logic            r_bready, w_bready_nxt;
    logic            r_arvalid, w_arvalid_nxt;
    logic            r_rready, w_rready_nxt;
    logic            r_wcomplete, w_wcomplete_nxt;
    logic            r_rcomplete, w_rcomplete_nxt;
    logic [AW-1:0]   r_awaddr, w_awaddr_nxt;
    logic [AW-1:0]   r_araddr, w_araddr_nxt;
    logic [DW-1:0]   r_wdata, w_wdata_nxt;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_aw_ok, w_w_ok, w_last;
    logic w_unused_inputs;

    function automatic logic [AW-1:0] f_addr(input logic [IW-1:0] i);
        return C_START_ADDR + (AW'(i) << 2);
    endfunction

    function automatic logic [DW-1:0] f_data(input logic [IW-1:0] i);
        return C_START_DATA + DW'(i);
    endfunction

    assign w_aw_hs   = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs    = r_wvalid  & M_AXI_WREADY;
    assign w_b_hs    = r_bready  & M_AXI_BVALID;
    assign w_ar_hs   = r_arvalid & M_AXI_ARREADY;
    assign w_r_hs    = r_rready  & M_AXI_RVALID;
    // AW and W may complete in either order; remember whichever came first
    assign w_aw_ok   = r_aw_done | w_aw_hs;
    assign w_w_ok    = r_w_done  | w_w_hs;
    assign w_idx_inc = r_idx + IW'(1);
    assign w_last    = (w_idx_inc == LAST_CNT);

    assign w_unused_inputs = ^{M_AXI_BRESP, M_AXI_RRESP, M_AXI_RDATA};

    // ---------------- state register ----------------
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) r_state <= S_IDLE;
        else                r_state <= w_state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:         w_state_nxt = S_WR_ADDR_DATA;
            S_WR_ADDR_DATA: if (w_aw_ok && w_w_ok) w_state_nxt = S_WR_RESP;
            S_WR_RESP:      if (w_b_hs) w_state_nxt = w_last ? S_RD_ADDR : S_WR_ADDR_DATA;
            S_RD_ADDR:      if (w_ar_hs) w_state_nxt = S_RD_DATA;
            S_RD_DATA:      if (w_r_hs) w_state_nxt = w_last ? S_DONE : S_RD_ADDR;
            S_DONE:         w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- outputs (next values of the registered bus signals) ----------------
    always_comb begin
        w_idx_nxt       = r_idx;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_wcomplete_nxt = r_wcomplete;
        w_rcomplete_nxt = r_rcomplete;
        w_awaddr_nxt    = r_awaddr;
        w_araddr_nxt    = r_araddr;
        w_wdata_nxt     = r_wdata;
        case (r_state)
            S_IDLE: begin
                w_awvalid_nxt = 1'b1;
                w_wvalid_nxt  = 1'b1;
                w_aw_done_nxt = 1'b0;
                w_w_done_nxt  = 1'b0;
                w_awaddr_nxt  = f_addr('0);
                w_wdata_nxt   = f_data('0);
            end
            S_WR_ADDR_DATA: begin
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                // BREADY only after both address and data are accepted
                if (w_aw_ok && w_w_ok) w_bready_nxt = 1'b1;
            end
            S_WR_RESP: begin
                if (w_b_hs) begin
                    w_bready_nxt = 1'b0;
                    if (w_last) begin
                        w_wcomplete_nxt = 1'b1;
                        w_idx_nxt       = '0;
                        w_arvalid_nxt   = 1'b1;
                        w_araddr_nxt    = f_addr('0);
                    end else begin
                        w_idx_nxt     = w_idx_inc;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_aw_done_nxt = 1'b0;
                        w_w_done_nxt  = 1'b0;
                        w_awaddr_nxt  = f_addr(w_idx_inc);
                        w_wdata_nxt   = f_data(w_idx_inc);
                    end
                end
            end
            S_RD_ADDR: begin
                if (w_ar_hs) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (w_r_hs) begin
                    w_rready_nxt = 1'b0;
                    if (w_last) begin
                        w_rcomplete_nxt = 1'b1;
                    end else begin
                        w_idx_nxt     = w_idx_inc;
                        w_arvalid_nxt = 1'b1;
                        w_araddr_nxt  = f_addr(w_idx_inc);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_idx       <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_wcomplete <= 1'b0;
            r_rcomplete <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_wcomplete <= w_wcomplete_nxt;
            r_rcomplete <= w_rcomplete_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_araddr    <= w_araddr_nxt;
            r_wdata     <= w_wdata_nxt;
        end
    end

    assign WCOMPLETE     = r_wcomplete;
    assign RCOMPLETE     = r_rcomplete;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_lite_master_1txn.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master_1txn
// Directed bench for axi_lite_master_1txn with four transactions. A slave
// process answers the bus under per-scenario knobs; the stimulus pushes the
// expected AW/W/AR beats into queues and a negedge monitor pops and compares
// them, and also tracks the completion flags and BREADY ordering.
// -----------------------------------------------------------------------------
module tb_axi_lite_master_1txn;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        WCOMPLETE, RCOMPLETE;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    // slave knobs
    int          aw_delay = 1;   // cycles AWVALID is high before the handshake
    logic [1:0]  bresp_k  = 2'b00;
    bit          b_early  = 1'b0;
    int          b_allow  = 99;  // B responses the slave will ever give
    int          r_allow  = 99;  // R responses the slave will ever give

    int checks = 0;
    int errors = 0;

    logic [31:0] aw_q[$], w_q[$], ar_q[$];
    logic [31:0] EXP_ADDR [N] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] EXP_DATA [N] = '{32'h1, 32'h2, 32'h3, 32'h4};

    always #5 clk = ~clk;

    axi_lite_master_1txn #(.C_TRANSACTIONS_NUM(N)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .WCOMPLETE(WCOMPLETE), .RCOMPLETE(RCOMPLETE),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected handshake, got 1 expected 0 (t=%0t)", name, $time);
    endtask

    // ---------------- slave model ----------------
    initial begin
        bit s_aw, s_w, s_b, s_ar, s_r;
        bit aw_got, w_got, ar_got;
        int aw_seen, b_given, r_given;
        {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
        BRESP = 2'b00; RRESP = 2'b00; RDATA = 32'hA5A5_0000;
        aw_got = 0; w_got = 0; ar_got = 0; aw_seen = 0; b_given = 0; r_given = 0;
        forever begin
            @(negedge clk);
            s_aw = AWVALID && AWREADY;
            s_w  = WVALID && WREADY;
            s_b  = BVALID && BREADY;
            s_ar = ARVALID && ARREADY;
            s_r  = RVALID && RREADY;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
                aw_got = 0; w_got = 0; ar_got = 0; aw_seen = 0; b_given = 0; r_given = 0;
            end else begin
                if (s_aw) aw_got = 1;
                if (s_w)  w_got  = 1;
                aw_seen = AWVALID ? aw_seen + 1 : 0;
                AWREADY = AWVALID && (aw_seen >= aw_delay);
                WREADY  = WVALID;
                BRESP   = bresp_k;
                if (s_b) begin
                    BVALID = 0; aw_got = 0; w_got = 0; b_given++;
                end else if (b_given < b_allow && ((aw_got && w_got) || (b_early && w_got))) begin
                    BVALID = 1;
                end
                ARREADY = ARVALID;
                if (s_ar) ar_got = 1;
                if (s_r) begin
                    RVALID = 0; ar_got = 0; r_given++;
                end else if (ar_got && r_given < r_allow) begin
                    RVALID = 1;
                    RDATA  = RDATA + 32'h1;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int b_cnt, r_cnt, aw_hi, w_hi;
        bit aw_seen, w_seen, wc_exp, rc_exp, awp_prev;
        logic [31:0] aw_prev_addr;
        b_cnt = 0; r_cnt = 0; aw_hi = 0; w_hi = 0;
        aw_seen = 0; w_seen = 0; wc_exp = 0; rc_exp = 0; awp_prev = 0; aw_prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_cnt = 0; r_cnt = 0; aw_hi = 0; w_hi = 0;
                aw_seen = 0; w_seen = 0; wc_exp = 0; rc_exp = 0; awp_prev = 0;
            end else begin
                chk("wcomplete", 64'(WCOMPLETE), 64'(wc_exp));
                chk("rcomplete", 64'(RCOMPLETE), 64'(rc_exp));
                if (rc_exp)
                    chk("done_bus_idle", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 64'(0));
                if (BREADY)
                    chk("bready_after_aw_w", 64'({aw_seen, w_seen}), 64'(2'b11));
                if (awp_prev)
                    chk("awaddr_held", 64'({AWVALID, AWADDR}), 64'({1'b1, aw_prev_addr}));
                aw_hi = AWVALID ? aw_hi + 1 : 0;
                w_hi  = WVALID  ? w_hi + 1  : 0;
                if (AWVALID && AWREADY) begin
                    if (aw_q.size() == 0) fail("aw_extra");
                    else chk("awaddr", 64'(AWADDR), 64'(aw_q.pop_front()));
                    chk("awprot", 64'(AWPROT), 64'(0));
                    chk("awvalid_cycles", 64'(aw_hi), 64'(aw_delay));
                    aw_seen = 1;
                end
                if (WVALID && WREADY) begin
                    if (w_q.size() == 0) fail("w_extra");
                    else chk("wdata", 64'(WDATA), 64'(w_q.pop_front()));
                    chk("wstrb", 64'(WSTRB), 64'(4'hF));
                    chk("wvalid_cycles", 64'(w_hi), 64'(1));
                    w_seen = 1;
                end
                if (BVALID && BREADY) begin
                    b_cnt++;
                    aw_seen = 0; w_seen = 0;
                    if (b_cnt == N) wc_exp = 1;
                end
                if (ARVALID && ARREADY) begin
                    if (ar_q.size() == 0) fail("ar_extra");
                    else chk("araddr", 64'(ARADDR), 64'(ar_q.pop_front()));
                    chk("arprot", 64'(ARPROT), 64'(0));
                end
                if (RVALID && RREADY) begin
                    r_cnt++;
                    if (r_cnt == N) rc_exp = 1;
                end
                awp_prev     = AWVALID && !AWREADY;
                aw_prev_addr = AWADDR;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic outputs_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, WCOMPLETE, RCOMPLETE}), 64'(0));
        chk({tag, "_awaddr"}, 64'(AWADDR), 64'(0));
        chk({tag, "_wdata"}, 64'(WDATA), 64'(0));
        chk({tag, "_araddr"}, 64'(ARADDR), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        aw_q.delete(); w_q.delete(); ar_q.delete();
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        for (int i = 0; i < N; i++) begin
            aw_q.push_back(EXP_ADDR[i]);
            w_q.push_back(EXP_DATA[i]);
            ar_q.push_back(EXP_ADDR[i]);
        end
        rst_n = 1'b1;
    endtask

    task automatic run_to_done(input string tag);
        int k = 0;
        while (!RCOMPLETE && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_rcomplete_seen"}, 64'(RCOMPLETE), 64'(1));
        repeat (5) @(negedge clk);
        chk({tag, "_queues_drained"}, 64'(aw_q.size() + w_q.size() + ar_q.size()), 64'(0));
    endtask

    initial begin
        // always-ready slave, OKAY responses
        do_reset();
        run_to_done("ready");

        // AWREADY held off 3 cycles, SLVERR, slave raises BVALID early
        aw_delay = 3; bresp_k = 2'b10; b_early = 1'b1;
        do_reset();
        run_to_done("slow_aw");
        aw_delay = 1; bresp_k = 2'b00; b_early = 1'b0;

        // reset while waiting for the second B response
        b_allow = 1;
        do_reset();
        begin
            int k = 0;
            while (!(BREADY && AWADDR == 32'h4) && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk("wr_resp2_reached", 64'({BREADY, AWADDR}), 64'({1'b1, 32'h4}));
        end
        #2 rst_n = 1'b0;
        #1 outputs_zero("async_rst");
        b_allow = 99;
        do_reset();
        @(negedge clk);
        chk("restart_awaddr", 64'({AWVALID, AWADDR, WDATA}), 64'({1'b1, 32'h0, 32'h1}));
        run_to_done("restart");

        // slave never returns read data
        r_allow = 0;
        do_reset();
        begin
            int k = 0;
            while (!RREADY && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk("rready_reached", 64'(RREADY), 64'(1));
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rhold_state", 64'({RREADY, RCOMPLETE, ARVALID, WCOMPLETE}), 64'(4'b1001));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_lite_master_1txn.md
Name: axi_lite_master_1txn

Overview:
- Self-starting AXI4-Lite master that exercises a slave register bank after reset, with no software involved.
- Issues C_TRANSACTIONS_NUM single-beat writes, then the same number of single-beat reads to the same addresses.
- Raises sticky completion flags when each phase finishes.
- Used in benches and bring-up to pulse a control register (for example a gate bit) of a peripheral such as a traffic generator.

Parameters:
- C_TRANSACTIONS_NUM, 1, number of write transactions and number of read transactions (range 1..256).
- C_M_AXI_ADDR_WIDTH, 32, address bus width.
- C_M_AXI_DATA_WIDTH, 32, data bus width (32 or 64).
- C_START_ADDR, 32'h0, address of transaction 0; transaction i uses C_START_ADDR + 4*i.
- C_START_DATA, 32'h1, write data of transaction 0; transaction i writes C_START_DATA + i.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  asynchronous active-low reset
- WCOMPLETE  out  1  sticky high once all writes have received BVALID
- RCOMPLETE  out  1  sticky high once all reads have received RVALID
- M_AXI_AWADDR  out  ADDR_W  write address
- M_AXI_AWPROT  out  3  constant 3'b000
- M_AXI_AWVALID  out  1  write address valid
- M_AXI_AWREADY  in  1  write address ready
- M_AXI_WDATA  out  DATA_W  write data
- M_AXI_WSTRB  out  DATA_W/8  constant all ones
- M_AXI_WVALID  out  1  write data valid
- M_AXI_WREADY  in  1  write data ready
- M_AXI_BRESP  in  2  write response (ignored)
- M_AXI_BVALID  in  1  write response valid
- M_AXI_BREADY  out  1  write response ready
- M_AXI_ARADDR  out  ADDR_W  read address
- M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARVALID  out  1  read address valid
- M_AXI_ARREADY  in  1  read address ready
- M_AXI_RDATA  in  DATA_W  read data (not checked)
- M_AXI_RRESP  in  2  read response (ignored)
- M_AXI_RVALID  in  1  read data valid
- M_AXI_RREADY  out  1  read data ready

Behaviour:
- Reset state: all VALID/READY outputs 0, WCOMPLETE=0, RCOMPLETE=0, address/data outputs 0, counters 0, FSM in IDLE.
- Reset is asynchronous and may assert mid-transaction; all outputs return to reset values immediately, and the sequence restarts from transaction 0 after release.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE -> WR_ADDR_DATA on the first clock edge after ARESETN is sampled high.
- On entry to WR_ADDR_DATA:
  - AWADDR = C_START_ADDR + 4*i and WDATA = C_START_DATA + i.
  - AWVALID and WVALID are asserted together on the same cycle.
- Each VALID drops independently on the cycle after its own handshake (VALID&&READY at a clock edge). Address/data are held stable while VALID is high.
- Both handshakes done (same or different cycles) -> WR_RESP with BREADY=1.
- BVALID&&BREADY -> BREADY=0, i incremented.
  - If i == C_TRANSACTIONS_NUM: WCOMPLETE=1 and go to RD_ADDR with i cleared.
  - Else return to WR_ADDR_DATA.
- A slave that asserts BVALID before both AW and W handshakes complete is a protocol violation; this master does not accept B early (BREADY stays 0).
- RD_ADDR: ARADDR = C_START_ADDR + 4*i, ARVALID=1 until ARREADY; then RD_DATA with RREADY=1.
- RVALID&&RREADY -> RREADY=0, i incremented.
  - If i == C_TRANSACTIONS_NUM: RCOMPLETE=1, go to DONE.
  - Else return to RD_ADDR.
- DONE: all VALID/READY outputs 0; WCOMPLETE and RCOMPLETE remain 1 until reset. No further traffic.
- Minimum latency with an always-ready slave: AW/W issued on cycle 1 after reset release, B accepted on cycle 2 at the earliest. At most one outstanding transaction at any time.
- BRESP/RRESP error codes do not alter the sequence.

Test Plan:
- Always-ready slave, default params -> exactly one write (AWADDR=0x0, WDATA=0x1, WSTRB=0xF), then one read of 0x0. WCOMPLETE rises the cycle after BVALID handshake; RCOMPLETE rises the cycle after R handshake; then bus idle.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 3 cycles with AWADDR stable. BREADY asserts only after both handshakes.
- C_TRANSACTIONS_NUM=4 -> writes to 0x0/0x4/0x8/0xC with data 1/2/3/4, then 4 reads in the same address order. WCOMPLETE is set after the 4th B; RCOMPLETE is set after the 4th R.
- Slave returns BRESP=2'b10 -> sequence continues unchanged and WCOMPLETE=1.
- ARESETN asserted while in WR_RESP -> all outputs go to 0 asynchronously. After release the write to 0x0 is reissued and the flags restart from 0.
- Slave withholds RVALID indefinitely -> RREADY stays 1 and RCOMPLETE stays 0; no new AR is issued.
